// File: rtl/memoredf_queue_pkg.sv
// Shared widths, types and elaboration helpers for the multi-queue BRAM FIFO.
package memoredf_queue_pkg;

    localparam int unsigned DEF_QUEUE_LENGTH = 32'd4;
    localparam int unsigned DEF_NB_QUEUES    = 32'd4;
    localparam int unsigned DEF_PTR_W        = $clog2(DEF_QUEUE_LENGTH);
    localparam int unsigned DEF_CNT_W        = DEF_PTR_W + 32'd1;
    localparam int unsigned DEF_ID_W         = (DEF_NB_QUEUES > 32'd1) ? $clog2(DEF_NB_QUEUES) : 32'd1;
    localparam int unsigned DEF_ADDR_W       = $clog2(DEF_NB_QUEUES * DEF_QUEUE_LENGTH);

    typedef logic [DEF_CNT_W-1:0] queue_count_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/queue_ptr_ctrl.sv
// Head/tail/count bookkeeping and status flags for one queue region.
// Optional high-water mark register enabled by MULTI_QUEUE_HWM_EN.
module queue_ptr_ctrl
    import memoredf_queue_pkg::*;
#(
    parameter  int QUEUE_LENGTH  = DEF_QUEUE_LENGTH,
    parameter  int REGISTER_SIZE = 32,
    localparam int PW            = $clog2(QUEUE_LENGTH),
    localparam int CW            = PW + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push_en,
    input  logic                     i_pop_en,
    input  logic                     i_push_req,
    input  logic [REGISTER_SIZE-1:0] i_threshold,
    output logic [PW-1:0]            o_head,
    output logic [PW-1:0]            o_tail,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_last_elem,
    output logic                     o_kill,
    output logic                     o_overflow,
    output logic [CW-1:0]            o_hwm
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_QL  = CW'(QUEUE_LENGTH);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [CW-1:0] w_count_nxt;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({i_push_en, i_pop_en})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, count and sticky overflow state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head     <= {PW{1'b0}};
            r_tail     <= {PW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (i_push_en) r_tail <= r_tail + PTR_ONE;
            if (i_pop_en)  r_head <= r_head + PTR_ONE;
            r_count <= w_count_nxt;
            if (i_push_req && o_full) r_overflow <= 1'b1;
        end
    end

    assign o_head      = r_head;
    assign o_tail      = r_tail;
    assign o_empty     = (r_count == {CW{1'b0}});
    assign o_full      = (r_count == CNT_QL);
    assign o_last_elem = (r_count == CNT_ONE);
    assign o_overflow  = r_overflow;
    // A zero threshold disables the kill request for this queue.
    assign o_kill      = (i_threshold != {REGISTER_SIZE{1'b0}}) &&
                         (REGISTER_SIZE'(r_count) >= i_threshold);

`ifdef MULTI_QUEUE_HWM_EN
    logic [CW-1:0] r_hwm;

    // Track the highest occupancy seen since reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hwm <= {CW{1'b0}};
        end else if (r_count > r_hwm) begin
            r_hwm <= r_count;
        end
    end

    assign o_hwm = r_hwm;
`else
    assign o_hwm = {CW{1'b0}};
`endif

endmodule

// File: rtl/multi_queue_bram.sv
// NB_QUEUES FIFOs sharing one simple-dual-port BRAM, each owning QUEUE_LENGTH words.
// Define MULTI_QUEUE_HWM_EN to enable the per-queue occupancy high-water marks.
module multi_queue_bram
    import memoredf_queue_pkg::*;
#(
    parameter  int DATA_SIZE     = 8,
    parameter  int QUEUE_LENGTH  = 4,
    parameter  int NB_QUEUES     = 4,
    parameter  int REGISTER_SIZE = 32,
    localparam int PW            = $clog2(QUEUE_LENGTH),
    localparam int CW            = PW + 1,
    localparam int IW            = id_width(NB_QUEUES),
    localparam int AW            = $clog2(NB_QUEUES * QUEUE_LENGTH)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NB_QUEUES*REGISTER_SIZE-1:0] higher_threshold,
    input  logic                               push_valid,
    input  logic [IW-1:0]                      push_id,
    input  logic [DATA_SIZE-1:0]               valueIn,
    input  logic                               pop_valid,
    input  logic [IW-1:0]                      pop_id,
    output logic [DATA_SIZE-1:0]               valueOut,
    output logic                               valueOutValid,
    output logic [NB_QUEUES-1:0]               empty,
    output logic [NB_QUEUES-1:0]               full,
    output logic [NB_QUEUES-1:0]               lastElem,
    output logic [NB_QUEUES-1:0]               kill_the_core,
    output logic [NB_QUEUES-1:0]               overflow,
    output logic [NB_QUEUES*CW-1:0]            occupancy_hwm,
    output logic                               bram_clka,
    output logic [DATA_SIZE-1:0]               bram_dina,
    output logic [AW-1:0]                      bram_addra,
    output logic                               bram_wea,
    output logic                               bram_ena,
    output logic                               bram_clkb,
    output logic                               bram_rstb,
    output logic [DATA_SIZE-1:0]               bram_dinb,
    output logic [AW-1:0]                      bram_addrb,
    output logic                               bram_enb,
    input  logic [DATA_SIZE-1:0]               bram_doutb
);

    if (!is_pow2(QUEUE_LENGTH) || (QUEUE_LENGTH < 2)) begin : g_bad_qlen
        $error("QUEUE_LENGTH must be a power of two and at least 2");
    end
    if (NB_QUEUES < 1) begin : g_bad_nbq
        $error("NB_QUEUES must be at least 1");
    end

    logic [PW-1:0]        w_head [NB_QUEUES];
    logic [PW-1:0]        w_tail [NB_QUEUES];
    logic [NB_QUEUES-1:0] w_push_sel;
    logic [NB_QUEUES-1:0] w_pop_sel;
    logic [NB_QUEUES-1:0] w_push_en;
    logic [NB_QUEUES-1:0] w_pop_en;
    logic [NB_QUEUES-1:0] w_push_req;
    logic [PW-1:0]        w_tail_sel;
    logic [PW-1:0]        w_head_sel;
    logic                 w_full_sel;
    logic                 w_empty_sel;
    logic                 w_push_acc;
    logic                 w_pop_acc;
    logic [IW+PW-1:0]     w_addra_full;
    logic [IW+PW-1:0]     w_addrb_full;
    logic                 r_value_out_valid;

    // Select the addressed queue's pointer and flag; ids with no queue select nothing.
    always_comb begin
        w_tail_sel  = {PW{1'b0}};
        w_head_sel  = {PW{1'b0}};
        w_full_sel  = 1'b0;
        w_empty_sel = 1'b0;
        for (int q = 0; q < NB_QUEUES; q++) begin
            w_tail_sel  = w_tail_sel | (w_push_sel[q] ? w_tail[q] : {PW{1'b0}});
            w_head_sel  = w_head_sel | (w_pop_sel[q]  ? w_head[q] : {PW{1'b0}});
            w_full_sel  = w_full_sel  | (w_push_sel[q] & full[q]);
            w_empty_sel = w_empty_sel | (w_pop_sel[q]  & empty[q]);
        end
    end

    assign w_push_acc = push_valid & (|w_push_sel) & ~w_full_sel;
    assign w_pop_acc  = pop_valid  & (|w_pop_sel)  & ~w_empty_sel;

    for (genvar q = 0; q < NB_QUEUES; q++) begin : g_queue
        assign w_push_sel[q] = (push_id == IW'(q));
        assign w_pop_sel[q]  = (pop_id  == IW'(q));
        assign w_push_en[q]  = w_push_acc & w_push_sel[q];
        assign w_pop_en[q]   = w_pop_acc  & w_pop_sel[q];
        assign w_push_req[q] = push_valid & w_push_sel[q];

        queue_ptr_ctrl #(
            .QUEUE_LENGTH  (QUEUE_LENGTH),
            .REGISTER_SIZE (REGISTER_SIZE)
        ) u_ctrl (
            .clock       (clock),
            .reset       (reset),
            .i_push_en   (w_push_en[q]),
            .i_pop_en    (w_pop_en[q]),
            .i_push_req  (w_push_req[q]),
            .i_threshold (higher_threshold[q*REGISTER_SIZE +: REGISTER_SIZE]),
            .o_head      (w_head[q]),
            .o_tail      (w_tail[q]),
            .o_empty     (empty[q]),
            .o_full      (full[q]),
            .o_last_elem (lastElem[q]),
            .o_kill      (kill_the_core[q]),
            .o_overflow  (overflow[q]),
            .o_hwm       (occupancy_hwm[q*CW +: CW])
        );
    end

    // Read data follows the accepted pop by exactly one BRAM cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_value_out_valid <= 1'b0;
        end else begin
            r_value_out_valid <= w_pop_acc;
        end
    end

    assign w_addra_full  = {push_id, w_tail_sel};
    assign w_addrb_full  = {pop_id, w_head_sel};

    assign bram_clka     = clock;
    assign bram_ena      = 1'b1;
    assign bram_wea      = w_push_acc;
    assign bram_addra    = w_addra_full[AW-1:0];
    assign bram_dina     = valueIn;

    assign bram_clkb     = clock;
    assign bram_rstb     = reset;
    assign bram_enb      = 1'b1;
    assign bram_dinb     = {DATA_SIZE{1'b0}};
    assign bram_addrb    = w_addrb_full[AW-1:0];

    assign valueOut      = bram_doutb;
    assign valueOutValid = r_value_out_valid;

endmodule

// File: doc/multi_queue_bram.md
Name: multi_queue_bram

Overview:
- Parametrised successor to the single-channel BRAM queue: NB_QUEUES independent FIFOs share one simple-dual-port BRAM, each FIFO owning a contiguous region of QUEUE_LENGTH words.
- Sits between the per-core request demux and the EDF scheduler. Provides per-queue occupancy flags and per-queue kill thresholds.
- Adds behaviour the single queue lacks: push/pop guards on full/empty, a registered read-valid matching BRAM latency, and sticky overflow flags.

Parameters:
- DATA_SIZE, 8, payload width in bits.
- QUEUE_LENGTH, 4, depth per queue; must be a power of two and at least 2.
- NB_QUEUES, 4, number of queues; must be at least 1.
- REGISTER_SIZE, 32, width of each threshold register.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- higher_threshold  in  NB_QUEUES*REGISTER_SIZE  per-queue kill thresholds; queue i uses slice i.
- push_valid  in  1  push request.
- push_id  in  clog2(NB_QUEUES) (min 1)  target queue.
- valueIn  in  DATA_SIZE  push payload.
- pop_valid  in  1  pop request.
- pop_id  in  clog2(NB_QUEUES) (min 1)  source queue.
- valueOut  out  DATA_SIZE  popped data (driven from bram_doutb).
- valueOutValid  out  1  valueOut holds the data of the pop accepted in the previous cycle.
- empty, full, lastElem, kill_the_core, overflow  out  NB_QUEUES each  per-queue flags.
- occupancy_hwm  out  NB_QUEUES*(clog2(QUEUE_LENGTH)+1)  high-water marks (optional feature).
- bram_clka, bram_dina, bram_addra, bram_wea, bram_ena  out  write port; address width AW = clog2(NB_QUEUES*QUEUE_LENGTH).
- bram_clkb, bram_rstb, bram_dinb, bram_addrb, bram_enb  out  read port.
- bram_doutb  in  DATA_SIZE  read data, 1-cycle latency.

Behaviour:
- Per queue i: head_i and tail_i are clog2(QUEUE_LENGTH)-bit pointers that wrap naturally; count_i is clog2(QUEUE_LENGTH)+1 bits.
- Physical address = {queue_id, pointer}.
- push_acc = push_valid & !full[push_id], using the registered flags from before the edge.
- pop_acc = pop_valid & !empty[pop_id].
- Rejected push: no write, and overflow[push_id] is set (sticky until reset).
- Rejected pop: no pointer change, and valueOutValid = 0 in the next cycle.
- Write port:
  - bram_wea = push_acc; bram_addra = {push_id, tail_push_id}; bram_dina = valueIn.
  - tail_push_id increments on acceptance.
- Read port:
  - bram_addrb = {pop_id, head_pop_id}, driven combinationally.
  - head_pop_id increments on pop_acc.
  - valueOutValid is registered from pop_acc, so data is valid exactly 1 cycle after acceptance.
  - bram_enb = bram_ena = 1; bram_dinb = 0; bram_rstb = reset; both BRAM clocks = clock.
- Counters:
  - push_acc & pop_acc on the same queue: count unchanged.
  - On different queues: each count updates independently.
- No read/write address collision can occur:
  - Same-queue addresses can only match when the queue is empty (pop rejected) or full (push rejected).
  - A push to a full queue is rejected even if a pop to the same queue is accepted that cycle.
- Flags, all combinational from count_i:
  - empty = (count == 0).
  - full = (count == QUEUE_LENGTH).
  - lastElem = (count == 1).
  - kill_the_core = (thr_i != 0) & (count_i >= thr_i), compared at REGISTER_SIZE width with count zero-extended.
- Reset values: all pointers, counts and overflow = 0; valueOutValid = 0; empty = all ones; full, lastElem, kill_the_core = 0.
- Reset asserted mid-operation:
  - All queues empty on the next cycle and the in-flight valueOutValid is cleared.
  - BRAM contents are not cleared.
- An out-of-range push_id or pop_id (>= NB_QUEUES) is treated as a rejected request with no overflow set.

Optional Feature:
- Macro: MULTI_QUEUE_HWM_EN.
- Defined: per-queue register hwm_i <= max(hwm_i, count_i) each cycle, reset to 0, driven on occupancy_hwm.
- Undefined: occupancy_hwm tied to 0 and no registers are inferred.

Decomposition:
- Package memoredf_queue_pkg:
  - localparams for pointer, count, id and address widths.
  - typedef queue_count_t.
  - function is_pow2 for parameter elaboration checks.
- Sub-module queue_ptr_ctrl: one instance per queue holding head, tail, count, overflow, hwm and flags.
  - Inputs: push_en, pop_en, push_req, threshold.
  - Top level handles id decode, the address mux and valueOutValid.

Test Plan:
- Reset, then push 0xA1,0xA2 to queue 2, then pop queue 2 twice -> valueOut 0xA1 then 0xA2, each with valueOutValid one cycle after the pop; empty[2] = 1 afterwards.
- Push 4 words to queue 0 (QUEUE_LENGTH = 4), then a 5th -> full[0] = 1, 5th write suppressed (bram_wea = 0), overflow[0] = 1; queue 0 pops return only the first 4 words.
- Pop an empty queue 1 -> no head change, valueOutValid = 0, no flag change.
- On a queue holding 2 words, push and pop the same queue in one cycle -> count stays 2; run 10 such cycles -> tail and head wrap correctly and data order is preserved.
- Push to queue 3 while popping queue 0 in the same cycle -> both accepted, counts 1 and (n-1), no cross-talk.
- higher_threshold[1] = 3: after 3 pushes kill_the_core[1] = 1, cleared after 1 pop; with threshold 0 it never asserts. With MULTI_QUEUE_HWM_EN defined, hwm[1] = 3 and stays 3 after the pops.
